// File: rtl/golden_nonce_collector.sv
// Round-robin collector of miner golden nonces into a FWFT FIFO; hit-to-out_valid latency 3 cycles.
// Backpressure: full FIFO holds hits pending per slot; a second hit on a held slot is dropped (sticky overflow).
module golden_nonce_collector #(
  parameter int NUM_MINERS      = 4,
  parameter int ID_W            = 2,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       hash_clk,
  input  logic                       reset,
  input  logic [NUM_MINERS-1:0]      golden_in,
  input  logic [32*NUM_MINERS-1:0]   nonce_in,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [31:0]                out_nonce,
  output logic [ID_W-1:0]            out_miner,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = 32 + ID_W;

  logic [NUM_MINERS-1:0]      golden_d;
  logic [NUM_MINERS-1:0]      pending;
  logic [31:0]                slot [NUM_MINERS];
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [ID_W-1:0]            rr;
  logic [ID_W-1:0]            rr_next;
  logic [ID_W-1:0]            grant_idx;
  logic                       grant_vld;
  logic                       pop;

  assign out_valid = (fifo_count != '0);
  assign out_nonce = mem[rd_ptr][ENTRY_W-1:ID_W];
  assign out_miner = mem[rd_ptr][ID_W-1:0];
  assign pop       = out_valid && out_ready;
  assign rr_next   = (grant_idx == ID_W'(NUM_MINERS - 1)) ? '0 : grant_idx + ID_W'(1);

  // Grant is gated on the registered count only, so a same-cycle pop never frees a full FIFO.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    idx       = 0;
    sel       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (fifo_count < (FIFO_DEPTH_LOG2 + 1)'(DEPTH)) begin
      for (int k = 0; k < NUM_MINERS; k++) begin
        idx = int'(rr) + k;
        if (idx >= NUM_MINERS) idx = idx - NUM_MINERS;
        sel = ID_W'(idx);
        if (!grant_vld && pending[sel]) begin
          grant_vld = 1'b1;
          grant_idx = sel;
        end
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset || flush) begin
      golden_d   <= '0;
      pending    <= '0;
      rr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      if (reset) begin
        overflow <= 1'b0;
        for (int i = 0; i < NUM_MINERS; i++) slot[i] <= '0;
        for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end
    end else begin
      golden_d <= golden_in;
      // The miner's nonce is valid one cycle after its golden pulse.
      for (int i = 0; i < NUM_MINERS; i++) begin
        if (golden_d[i]) begin
          if (pending[i] && !(grant_vld && grant_idx == ID_W'(i))) begin
            overflow <= 1'b1;
          end else begin
            slot[i]    <= nonce_in[32*i +: 32];
            pending[i] <= 1'b1;
          end
        end else if (grant_vld && grant_idx == ID_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_vld) begin
        mem[wr_ptr] <= {slot[grant_idx], grant_idx};
        wr_ptr      <= wr_ptr + FIFO_DEPTH_LOG2'(1);
        rr          <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      if (grant_vld && !pop)      fifo_count <= fifo_count + (FIFO_DEPTH_LOG2 + 1)'(1);
      else if (!grant_vld && pop) fifo_count <= fifo_count - (FIFO_DEPTH_LOG2 + 1)'(1);
    end
  end
endmodule

// File: tb/tb_golden_nonce_collector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_golden_nonce_collector;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int L = 3;
  localparam int DEPTH = 8;

  logic             hash_clk = 1'b0;
  logic             reset, flush, out_ready;
  logic [N-1:0]     golden_in;
  logic [31:0]      nv [N];
  logic [32*N-1:0]  nonce_in;
  logic             out_valid, overflow;
  logic [31:0]      out_nonce;
  logic [IDW-1:0]   out_miner;
  logic [L:0]       fifo_count;

  assign nonce_in = {nv[3], nv[2], nv[1], nv[0]};
  always #5 hash_clk = ~hash_clk;

  golden_nonce_collector #(.NUM_MINERS(N), .ID_W(IDW), .FIFO_DEPTH_LOG2(L)) dut (
    .hash_clk(hash_clk), .reset(reset), .golden_in(golden_in), .nonce_in(nonce_in),
    .flush(flush), .out_valid(out_valid), .out_nonce(out_nonce), .out_miner(out_miner),
    .out_ready(out_ready), .overflow(overflow), .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-miner hit flags, a queue of {nonce, miner}, sticky drop flag.
  logic [33:0] m_q[$];
  bit          m_gd [N];
  bit          m_pend [N];
  logic [31:0] m_slot [N];
  int          m_rr;
  bit          m_ovf;
  logic [33:0] obs[$];

  function automatic void model_update();
    int g;
    bit gv;
    if (reset || flush) begin
      for (int i = 0; i < N; i++) begin m_gd[i] = 0; m_pend[i] = 0; end
      m_q.delete();
      m_rr = 0;
      if (reset) m_ovf = 0;
      return;
    end
    gv = 0; g = 0;
    if (m_q.size() < DEPTH)
      for (int k = 0; k < N; k++)
        if (!gv && m_pend[(m_rr + k) % N]) begin gv = 1; g = (m_rr + k) % N; end
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    if (gv) begin
      m_q.push_back({m_slot[g], 2'(g)});
      m_pend[g] = 0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (m_gd[i]) begin
        if (m_pend[i]) m_ovf = 1;
        else begin m_slot[i] = nv[i]; m_pend[i] = 1; end
      end
    for (int i = 0; i < N; i++) m_gd[i] = golden_in[i];
  endfunction

  task automatic step();
    if (out_valid && out_ready && !reset && !flush) obs.push_back({out_nonce, out_miner});
    model_update();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic idle(input int n);
    golden_in = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; golden_in = '0; flush = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic hit_mask(input logic [N-1:0] mask, input logic [31:0] base);
    golden_in = mask;
    step();
    golden_in = '0;
    for (int i = 0; i < N; i++) if (mask[i]) nv[i] = base + 32'(i);
    step();
  endtask

  task automatic hit(input int miner, input logic [31:0] val);
    golden_in = '0;
    golden_in[miner] = 1'b1;
    step();
    golden_in = '0;
    nv[miner] = val;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_nonce !== 32'h0) begin errors++; $display("FAIL reset_nonce got %h want 0", out_nonce); end
    checks++; if (out_miner !== 2'd0) begin errors++; $display("FAIL reset_miner got %0d want 0", out_miner); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_single_hit();
    do_reset();
    out_ready = 1'b0;
    golden_in = 4'b0100;
    step();
    golden_in = '0;
    nv[2] = 32'h0001_D9C3;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t3 got %b want 1", out_valid); end
    checks++; if (out_nonce !== 32'h0001_D9C3) begin errors++; $display("FAIL single_nonce got %h want 0001d9c3", out_nonce); end
    checks++; if (out_miner !== 2'd2) begin errors++; $display("FAIL single_miner got %0d want 2", out_miner); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [33:0] exp, got;
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      obs.delete();
      hit_mask(4'hF, 32'(10 + 10 * b));
      idle(8);
      checks++; if (obs.size() != 4) begin errors++; $display("FAIL simul_count burst %0d got %0d want 4", b, obs.size()); end
      for (int k = 0; k < 4; k++) begin
        exp = {32'(10 + 10 * b + k), 2'(k)};
        got = (k < obs.size()) ? obs[k] : 'x;
        checks++; if (got !== exp) begin errors++; $display("FAIL simul_order burst %0d pos %0d got %h want %h", b, k, got, exp); end
      end
    end
  endtask

  task automatic test_fairness();
    logic [33:0] exp [3];
    logic [33:0] got;
    do_reset();
    out_ready = 1'b1;
    obs.delete();
    hit(1, 32'd100);
    hit_mask(4'b1001, 32'd200);
    idle(8);
    exp[0] = {32'd100, 2'd1}; exp[1] = {32'd203, 2'd3}; exp[2] = {32'd200, 2'd0};
    for (int k = 0; k < 3; k++) begin
      got = (k < obs.size()) ? obs[k] : 'x;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL rr_order pos %0d got %h want %h", k, got, exp[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp, got;
    do_reset();
    out_ready = 1'b0;
    obs.delete();
    for (int k = 0; k < 8; k++) hit(k % 4, 32'hA000 + 32'(k));
    idle(2);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", fifo_count); end
    hit(0, 32'hA008);
    idle(1);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_hold_count got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b want 0", overflow); end
    hit(0, 32'hA009);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL collision_ovf got %b want 1", overflow); end
    out_ready = 1'b1;
    idle(14);
    checks++; if (obs.size() != 9) begin errors++; $display("FAIL drain_count got %0d want 9", obs.size()); end
    for (int k = 0; k < 9; k++) begin
      exp = {32'hA000 + 32'(k), 2'(k % 4)};
      got = (k < obs.size()) ? obs[k] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL drain_order pos %0d got %h want %h", k, got, exp); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    obs.delete();
    hit(0, 32'hB000); hit(1, 32'hB001); hit(2, 32'hB002);
    idle(1);
    hit(3, 32'hB003);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL preflush_count got %0d want 3", fifo_count); end
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got %b want 1", overflow); end
    idle(6);
    checks++; if (obs.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_output got %0d outputs valid=%b want 0", obs.size(), out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) hit(k, 32'hD000 + 32'(k));
    idle(1);
    checks++; if (fifo_count !== 4'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL premid_state got count=%0d ovf=%b want 4/1", fifo_count, overflow);
    end
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
    checks++; if (out_nonce !== 32'h0 || out_miner !== 2'd0) begin
      errors++; $display("FAIL mid_head got %h/%0d want 0/0", out_nonce, out_miner);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", overflow); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    hit(1, 32'hC0DE_0001);
    step();
    checks++; if (out_valid !== 1'b1 || out_nonce !== 32'hC0DE_0001 || out_miner !== 2'd1) begin
      errors++; $display("FAIL mid_after_hit got v=%b %h/%0d want 1 c0de0001/1", out_valid, out_nonce, out_miner);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        golden_in[i] = ($urandom_range(0, 3) == 0);
        nv[i] = $urandom;
      end
      if (((c / 200) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
      else                      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 149) == 0);
      step();
      flush = 1'b0;
      checks++; if (fifo_count !== 4'(m_q.size())) begin
        errors++; $display("FAIL rnd_count cycle %0d got %0d want %0d", c, fifo_count, m_q.size());
      end
      checks++; if (out_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cycle %0d got %b want %b", c, out_valid, m_q.size() != 0);
      end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cycle %0d got %b want %b", c, overflow, m_ovf);
      end
      if (m_q.size() != 0) begin
        checks++; if ({out_nonce, out_miner} !== m_q[0]) begin
          errors++; $display("FAIL rnd_head cycle %0d got %h want %h", c, {out_nonce, out_miner}, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; golden_in = '0;
    for (int i = 0; i < N; i++) begin
      nv[i] = '0; m_gd[i] = 0; m_pend[i] = 0; m_slot[i] = '0;
    end
    m_rr = 0; m_ovf = 0;
    #2;
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
